// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator.
//   state_t    : fetch FSM states (BOOT, RUN, HALT)
//   ALIGN_MASK : PC low bits that must be zero; set bits in a redirect
//                target are cleared and reported as misaligned.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer of RAS_DEPTH entries.
//   clk, rst  : clock, synchronous active-high reset (pointer/count only)
//   push      : write push_data as new top
//   pop       : remove top (ignored when empty)
//   push+pop  : replace top in place, pointer unchanged (plain push if empty)
//   top       : current top-of-stack
//   empty/full: occupancy status; a push when full overwrites the oldest
//               entry and full stays high
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   sp;      // next slot to write; wraps, so oldest is overwritten
  logic [PW-1:0]   sp_top;  // slot holding the current top
  logic [PW:0]     cnt;

  assign sp_top = sp - PW'(1);
  assign top    = mem[sp_top];
  assign empty  = (cnt == '0);
  assign full   = (cnt == (PW+1)'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push && pop && !empty) begin
      mem[sp_top] <= push_data;
    end else if (push) begin
      mem[sp] <= push_data;
      sp      <= sp + PW'(1);
      if (!full) cnt <= cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      sp  <= sp_top;
      cnt <= cnt - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with BOOT/RUN/HALT fetch FSM.
// Optional return-address stack enabled by macro PC_GEN_RAS_EN; without it
// call/ret are ignored, ras_empty=1, ras_full=0 and no stack exists.
//   clk, rst            : clock, synchronous active-high reset
//   branch, zero        : taken branch = branch & zero, target branch_dest
//   jump, jump_dest     : unconditional redirect
//   trap, trap_vec      : exception redirect, honoured in every state
//   call, ret           : RAS push / pop (only when the PC advances)
//   halt, resume        : freeze / unfreeze fetch (halt wins)
//   stall               : hold PC this cycle
//   pc, pc_valid        : registered PC, valid in RUN without stall
//   misalign            : one-cycle pulse after a misaligned redirect
//   ras_empty, ras_full : stack status
module pc_gen import pc_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] branch_dest,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_dest,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            call,
  input  logic            ret,
  input  logic            halt,
  input  logic            resume,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign,
  output logic            ras_empty,
  output logic            ras_full
);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_seq, pc_nxt, tgt, ras_top;
  logic            redir, mis_nxt, ret_hit;

  assign pc_seq   = pc + XLEN'(INC);  // wraps silently
  assign pc_valid = (state == RUN) && !stall;

`ifdef PC_GEN_RAS_EN
  logic advance, ras_push, ras_pop;

  // The stack only moves when this PC is actually consumed.
  assign advance  = (state == RUN) && !stall && !trap;
  assign ras_push = advance && call;
  assign ras_pop  = advance && ret;
  assign ret_hit  = ras_pop && !ras_empty;  // empty ret falls through

  pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = &{1'b0, call, ret};
  assign ret_hit    = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tgt       = trap_vec;
    redir     = 1'b0;
    if (trap) begin
      redir     = 1'b1;
      state_nxt = RUN;
    end else begin
      case (state)
        BOOT: state_nxt = RUN;
        RUN: begin
          if (!stall) begin
            if (ret_hit) begin
              tgt   = ras_top;
              redir = 1'b1;
            end else if (jump) begin
              tgt   = jump_dest;
              redir = 1'b1;
            end else if (branch && zero) begin
              tgt   = branch_dest;
              redir = 1'b1;
            end else begin
              pc_nxt = pc_seq;
            end
          end
          // The current PC is still consumed; fetch freezes from next cycle.
          if (halt) state_nxt = HALT;
        end
        HALT: if (resume && !halt) state_nxt = RUN;
        default: state_nxt = BOOT;
      endcase
    end
    mis_nxt = redir && |(tgt[1:0] & ALIGN_MASK);
    if (redir) pc_nxt = {tgt[XLEN-1:2], tgt[1:0] & ~ALIGN_MASK};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      misalign <= mis_nxt;
    end
  end

endmodule
